// File: rtl/lag_pl_status_tracker.sv
// Per-port, per-PL allocation state and downstream credit tracker for the LAG router.
// Feeds the pl_status free-vector to the PL allocator and credit availability to the switch stage.

module lag_pl_slot #(
  parameter int buf_len = 4,
  parameter int cw      = $clog2(buf_len + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  logic          sent,
  input  logic          tail,
  input  logic          credit,
  output logic          status,
  output logic          avail,
  output logic [cw-1:0] cnt,
  output logic          proto_ev,
  output logic          credit_ev
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  localparam logic [cw:0] FULL = (cw+1)'(buf_len);

  state_t      state, state_nxt;
  logic [cw:0] cnt_ext, cnt_nxt;

  // Underflow wraps to all-ones and overflow lands on FULL+1; both exceed FULL.
  always_comb begin
    cnt_ext   = {1'b0, cnt} + {{cw{1'b0}}, credit} - {{cw{1'b0}}, sent};
    cnt_nxt   = cnt_ext;
    credit_ev = 1'b0;
    if (cnt_ext > FULL) begin
      cnt_nxt   = {1'b0, cnt};
      credit_ev = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= cw'(buf_len);
    else        cnt <= cnt_nxt[cw-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (alloc) state_nxt = ACTIVE;
      ACTIVE:  if (sent && tail) state_nxt = (cnt_nxt == FULL) ? IDLE : DRAIN;
      DRAIN:   if (cnt_nxt == FULL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status   = (state == IDLE);
    avail    = (cnt != '0);
    proto_ev = (alloc && state != IDLE) || (sent && state != ACTIVE);
  end
endmodule

module lag_pl_status_tracker #(
  parameter int np      = 5,
  parameter int nv      = 4,
  parameter int buf_len = 4,
  parameter int cw      = $clog2(buf_len + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [np-1:0][nv-1:0]        pl_allocated,
  input  logic [np-1:0][nv-1:0]        flit_sent,
  input  logic [np-1:0][nv-1:0]        flit_tail,
  input  logic [np-1:0][nv-1:0]        credit_in,
  output logic [np-1:0][nv-1:0]        pl_status,
  output logic [np-1:0][nv-1:0]        credit_avail,
  output logic [np-1:0][nv-1:0][cw-1:0] credit_count,
  output logic                         err_protocol,
  output logic                         err_credit
);
  logic [np-1:0][nv-1:0] proto_ev, credit_ev;

  for (genvar p = 0; p < np; p++) begin : g_port
    for (genvar v = 0; v < nv; v++) begin : g_pl
      lag_pl_slot #(.buf_len(buf_len), .cw(cw)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (pl_allocated[p][v]),
        .sent      (flit_sent[p][v]),
        .tail      (flit_tail[p][v]),
        .credit    (credit_in[p][v]),
        .status    (pl_status[p][v]),
        .avail     (credit_avail[p][v]),
        .cnt       (credit_count[p][v]),
        .proto_ev  (proto_ev[p][v]),
        .credit_ev (credit_ev[p][v])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_protocol <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      err_protocol <= err_protocol | (|proto_ev);
      err_credit   <= err_credit   | (|credit_ev);
    end
  end
endmodule
